// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: data width, the NOP and
// HALT encodings, and the fetch-stage FSM state encoding.
package mips_pkg;

    localparam int NB_DATA = 32;

    localparam logic [NB_DATA-1:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [NB_DATA-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one synchronous write port used by the
// loader and one combinational read port used by the fetch stage.
// Contents are intentionally not reset.
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

    // Loader write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, fetch FSM and the IF/ID register.
// Optional build macro IF_FETCH_COUNT_EN adds a saturating o_fetch_count of
// instructions delivered to decode (cleared on each accepted start).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | after reset; PC=0, bubble out, loader may write imem
// ST_RUN    | fetching; jump > stall > normal fetch/halt detection
// ST_HALTED | HALT word seen; PC frozen, o_halt=1, loader may write imem
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                 NB_DATA   = mips_pkg::NB_DATA,
    parameter int                 NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [NB_DATA-1:0] i_jump_addr,
    input  logic               i_imem_we,
    input  logic [NB_ADDR-1:0] i_imem_waddr,
    input  logic [NB_DATA-1:0] i_imem_wdata,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_DATA-1:0] o_pcounter4,
    output logic [NB_DATA-1:0] o_pc,
    output logic               o_valid,
    output logic               o_halt
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0]        o_fetch_count
`endif
);

    fetch_state_e       state_q, state_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic               halt_q, halt_d;
    logic [NB_DATA-1:0] fetch_word;
    logic               imem_we;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0]        cnt_q, cnt_d;
`endif

    // The loader only owns the memory while the core is not fetching.
    assign imem_we = i_imem_we && (state_q != ST_RUN);

    instruction_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .clk     (clk),
        .i_we    (imem_we),
        .i_waddr (i_imem_waddr),
        .i_wdata (i_imem_wdata),
        .i_raddr (pc_q[NB_ADDR+1:2]),
        .o_rdata (fetch_word)
    );

    // Next-state logic: FSM transitions, PC update and IF/ID load/bubble/hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        halt_d  = halt_q;
`ifdef IF_FETCH_COUNT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    halt_d  = 1'b0;
`ifdef IF_FETCH_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_RUN: begin
                if (i_jump) begin
                    // The word fetched this cycle is dropped, even a HALT.
                    pc_d    = i_jump_addr;
                    instr_d = NOP_WORD;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (!i_stall) begin
                    if (fetch_word == HALT_WORD) begin
                        state_d = ST_HALTED;
                        instr_d = NOP_WORD;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                        halt_d  = 1'b1;
                    end else begin
                        instr_d = fetch_word;
                        pc4_d   = pc_q + NB_DATA'(4);
                        valid_d = 1'b1;
                        pc_d    = pc_q + NB_DATA'(4);
`ifdef IF_FETCH_COUNT_EN
                        if (cnt_q != 32'hFFFF_FFFF) begin
                            cnt_d = cnt_q + 32'd1;
                        end
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    // Delivered-instruction counter.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_fetch_count = cnt_q;
`endif

    assign o_instruction = instr_q;
    assign o_pcounter4   = pc4_q;
    assign o_pc          = pc_q;
    assign o_valid       = valid_q;
    assign o_halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized
// start/stall/jump/load traffic, all checked against a behavioural model.
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start, i_stall, i_jump, i_imem_we;
    logic [31:0] i_jump_addr, i_imem_wdata;
    logic [7:0]  i_imem_waddr;
    logic [31:0] o_instruction, o_pcounter4, o_pc;
    logic        o_valid, o_halt;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0] o_fetch_count;
`endif

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_stall       (i_stall),
        .i_jump        (i_jump),
        .i_jump_addr   (i_jump_addr),
        .i_imem_we     (i_imem_we),
        .i_imem_waddr  (i_imem_waddr),
        .i_imem_wdata  (i_imem_wdata),
        .o_instruction (o_instruction),
        .o_pcounter4   (o_pcounter4),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .o_halt        (o_halt)
`ifdef IF_FETCH_COUNT_EN
        ,
        .o_fetch_count (o_fetch_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: "running" flag plus the architectural view of the stage.
    bit          m_running, m_halted;
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    bit          m_valid;

    task automatic model_reset();
        m_running = 0; m_halted = 0;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit st, input bit sl, input bit jp, input logic [31:0] ja,
                              input bit we, input logic [7:0] wa, input logic [31:0] wd);
        logic [31:0] w;
        if (m_running) begin
            if (jp) begin
                m_pc = ja; m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!sl) begin
                w = m_mem[(m_pc / 4) % 256];
                if (w == HALT) begin
                    m_instr = 0; m_pc4 = 0; m_valid = 0;
                    m_running = 0; m_halted = 1;
                end else begin
                    m_instr = w; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end
            end
        end else begin
            if (we) m_mem[wa] = wd;
            if (st) begin
                m_running = 1; m_halted = 0; m_pc = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check_eq({ctx, ".instr"}, o_instruction, m_instr);
        check_eq({ctx, ".pc4"},   o_pcounter4,   m_pc4);
        check_eq({ctx, ".pc"},    o_pc,          m_pc);
        check_eq({ctx, ".valid"}, 32'(o_valid),  32'(m_valid));
        check_eq({ctx, ".halt"},  32'(o_halt),   32'(m_halted));
`ifdef IF_FETCH_COUNT_EN
        check_eq({ctx, ".count"}, o_fetch_count, m_cnt);
`endif
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cycle(input string ctx, input bit st, input bit sl, input bit jp,
                         input logic [31:0] ja, input bit we, input logic [7:0] wa,
                         input logic [31:0] wd);
        i_start = st; i_stall = sl; i_jump = jp; i_jump_addr = ja;
        i_imem_we = we; i_imem_waddr = wa; i_imem_wdata = wd;
        @(posedge clk);
        model_step(st, sl, jp, ja, we, wa, wd);
        @(negedge clk);
        compare_all(ctx);
    endtask

    task automatic idle_cyc(input string ctx);
        cycle(ctx, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        cycle("load", 0, 0, 0, 0, 1, a, d);
    endtask

    task automatic start();
        cycle("start", 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        i_rst_n = 0;
        i_start = 0; i_stall = 0; i_jump = 0; i_jump_addr = 0;
        i_imem_we = 0; i_imem_waddr = 0; i_imem_wdata = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 'x;
        model_reset();
        @(negedge clk);
        compare_all("reset");
        @(negedge clk);
        i_rst_n = 1;

        // Program: three arithmetic words then HALT; a target block at 0x40.
        load(0, 32'h2001_0005);
        load(1, 32'h2002_0003);
        load(2, 32'h0022_1820);
        load(3, HALT);
        load(16, 32'h1234_5678);
        load(17, HALT);

        // Straight-line run to HALT.
        start();
        for (int k = 0; k < 3; k++) begin
            idle_cyc("seq");
            check_eq("seq.pc4_const", o_pcounter4, 32'(4 * (k + 1)));
        end
        idle_cyc("seq_halt");
        check_eq("halt_flag", 32'(o_halt), 1);
        check_eq("halt_pc", o_pc, 12);
`ifdef IF_FETCH_COUNT_EN
        check_eq("fetch_count", o_fetch_count, 3);
`endif
        idle_cyc("halted_hold");
        check_eq("halted_pc_hold", o_pc, 12);

        // Stall for three cycles at PC=8.
        start();
        idle_cyc("st_a");
        idle_cyc("st_b");
        for (int k = 0; k < 3; k++) begin
            cycle("stall", 0, 1, 0, 0, 0, 0, 0);
            check_eq("stall_pc", o_pc, 8);
            check_eq("stall_instr", o_instruction, 32'h2002_0003);
            check_eq("stall_pc4", o_pcounter4, 8);
        end
        idle_cyc("resume");
        check_eq("resume_pc", o_pc, 12);
        check_eq("resume_instr", o_instruction, 32'h0022_1820);
        idle_cyc("resume_halt");

        // Jump at PC=4 to 0x40.
        start();
        idle_cyc("j_pre");
        cycle("jump", 0, 0, 1, 32'h40, 0, 0, 0);
        check_eq("jump_bubble_valid", 32'(o_valid), 0);
        check_eq("jump_bubble_instr", o_instruction, 0);
        idle_cyc("j_tgt");
        check_eq("jump_tgt_instr", o_instruction, 32'h1234_5678);
        check_eq("jump_tgt_pc4", o_pcounter4, 32'h44);
        idle_cyc("j_halt");

        // Jump and stall together, unaligned target.
        start();
        cycle("jump_stall", 0, 1, 1, 32'h43, 0, 0, 0);
        check_eq("js_pc", o_pc, 32'h43);
        check_eq("js_valid", 32'(o_valid), 0);
        idle_cyc("js_tgt");
        check_eq("js_tgt_instr", o_instruction, 32'h1234_5678);
        idle_cyc("js_halt");

        // Jump in the cycle HALT is being fetched; write during RUN ignored.
        start();
        cycle("wr_run", 0, 0, 0, 0, 1, 16, 32'hDEAD_BEEF);
        idle_cyc("hj_b");
        idle_cyc("hj_c");
        cycle("halt_jump", 0, 0, 1, 32'h40, 0, 0, 0);
        check_eq("hj_no_halt", 32'(o_halt), 0);
        idle_cyc("hj_tgt");
        check_eq("wr_run_ignored", o_instruction, 32'h1234_5678);

        // Asynchronous reset mid-run.
        start();
        idle_cyc("rst_a");
        #2 i_rst_n = 0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        i_rst_n = 1;
        idle_cyc("post_rst_idle");

        // Randomized phase: full memory load, then random traffic.
        for (int a = 0; a < 256; a++)
            load(8'(a), ($urandom_range(0, 15) == 0) ? HALT : $urandom);
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ja, wd;
            ja = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
            wd = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            cycle("rand",
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  ja,
                  ($urandom_range(0, 2) == 0),
                  8'($urandom),
                  wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
